// File: rtl/e_mdu.sv
// Multiply/divide unit for the E stage. It owns HI/LO, runs MULT/DIV over a
// fixed per-op latency and serves MFHI/MFLO reads combinationally.
module e_mdu #(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] dataA,
   input  logic [WIDTH-1:0] dataB,
   input  logic [3:0]       MDUctrl,
   input  logic             start,
   output logic             busy,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO,
   output logic [WIDTH-1:0] result
);

   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MFHI  = 4'd5;
   localparam logic [3:0] OP_MFLO  = 4'd6;
   localparam logic [3:0] OP_MTHI  = 4'd7;
   localparam logic [3:0] OP_MTLO  = 4'd8;

   typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] pend_hi, pend_lo, hi_q, lo_q;
   logic [WIDTH-1:0] nxt_hi, nxt_lo;
   logic             is_mul, is_div, accept, expire, idle_start;

   logic [2*WIDTH-1:0] ext_a, ext_b, prod;
   logic               neg_a, neg_b;
   logic [WIDTH-1:0]   mag_a, mag_b, uq, ur;

   assign is_mul     = (MDUctrl == OP_MULT) || (MDUctrl == OP_MULTU);
   assign is_div     = (MDUctrl == OP_DIV) || (MDUctrl == OP_DIVU);
   assign idle_start = (state == S_IDLE) && start;
   assign accept     = idle_start && (is_mul || is_div);
   assign expire     = (state == S_BUSY) && (cnt == CW'(1));

   // Signed divide works on magnitudes so the most-negative / -1 case wraps
   // naturally to quotient = most-negative, remainder = 0.
   always_comb begin
      ext_a  = {{WIDTH{(MDUctrl == OP_MULT) & dataA[WIDTH-1]}}, dataA};
      ext_b  = {{WIDTH{(MDUctrl == OP_MULT) & dataB[WIDTH-1]}}, dataB};
      prod   = ext_a * ext_b;
      neg_a  = (MDUctrl == OP_DIV) & dataA[WIDTH-1];
      neg_b  = (MDUctrl == OP_DIV) & dataB[WIDTH-1];
      mag_a  = neg_a ? ('0 - dataA) : dataA;
      mag_b  = neg_b ? ('0 - dataB) : dataB;
      if (dataB == '0) begin
         uq = '0;
         ur = '0;
      end else begin
         uq = mag_a / mag_b;
         ur = mag_a % mag_b;
      end
      nxt_hi = prod[2*WIDTH-1:WIDTH];
      nxt_lo = prod[WIDTH-1:0];
      if (is_div) begin
         if (dataB == '0) begin
            nxt_hi = dataA;
            nxt_lo = '1;
         end else begin
            nxt_hi = neg_a ? ('0 - ur) : ur;
            nxt_lo = (neg_a ^ neg_b) ? ('0 - uq) : uq;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (accept) state_nxt = S_BUSY;
         S_BUSY: if (cnt == CW'(1)) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (state == S_BUSY);
      case (MDUctrl)
         OP_MFHI: result = hi_q;
         OP_MFLO: result = lo_q;
         default: result = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt     <= '0;
         pend_hi <= '0;
         pend_lo <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         if (accept) begin
            cnt     <= is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            pend_hi <= nxt_hi;
            pend_lo <= nxt_lo;
         end else if (state == S_BUSY) begin
            cnt <= cnt - CW'(1);
         end
         // MT writes are only possible in IDLE, so they never collide with writeback.
         if (expire)                                 hi_q <= pend_hi;
         else if (idle_start && MDUctrl == OP_MTHI) hi_q <= dataA;
         if (expire)                                 lo_q <= pend_lo;
         else if (idle_start && MDUctrl == OP_MTLO) lo_q <= dataA;
      end
   end

   assign HI = hi_q;
   assign LO = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// Bench for e_mdu: a 32-bit default build and a 16-bit/1/3-cycle build, each
// with a scoreboard monitor that checks HI/LO and busy length at writeback.
module tb_e_mdu;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] dataA, dataB, HI, LO, result;
   logic [3:0]  MDUctrl;
   logic        start, busy;

   logic [15:0] s_dataA, s_dataB, s_hi, s_lo, s_result;
   logic [3:0]  s_ctrl;
   logic        s_start, s_busy;

   int checks = 0;
   int errors = 0;

   logic [63:0] exp_q[$];
   int          lat_q[$];
   logic [63:0] s_exp_q[$];
   int          s_lat_q[$];
   logic [31:0] m_hi, m_lo;

   always #5 clk = ~clk;

   e_mdu dut (
      .clk(clk), .reset(reset), .dataA(dataA), .dataB(dataB), .MDUctrl(MDUctrl),
      .start(start), .busy(busy), .HI(HI), .LO(LO), .result(result)
   );

   e_mdu #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(3)) dut_s (
      .clk(clk), .reset(reset), .dataA(s_dataA), .dataB(s_dataB), .MDUctrl(s_ctrl),
      .start(s_start), .busy(s_busy), .HI(s_hi), .LO(s_lo), .result(s_result)
   );

   // Reference: plain integer arithmetic on w-bit values, returns {hi, lo}.
   function automatic logic [63:0] ref_md(int w, logic [3:0] op, logic [31:0] a, logic [31:0] b);
      logic [63:0] mask, hi, lo, p;
      longint      sa, sb, q, r;
      mask = (64'd1 << w) - 64'd1;
      sa = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
      sb = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
      hi = '0;
      lo = '0;
      case (op)
         4'd1: begin p = sa * sb; hi = (p >> w) & mask; lo = p & mask; end
         4'd2: begin p = {32'b0, a} * {32'b0, b}; hi = (p >> w) & mask; lo = p & mask; end
         4'd3, 4'd4: begin
            if (b == 0) begin
               hi = {32'b0, a};
               lo = mask;
            end else if (op == 4'd3) begin
               q = sa / sb; r = sa % sb;
               hi = r & mask; lo = q & mask;
            end else begin
               hi = {32'b0, a % b}; lo = {32'b0, a / b};
            end
         end
         default: ;
      endcase
      return {hi[31:0], lo[31:0]};
   endfunction

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Monitors: a falling busy marks a writeback; pop and compare.
   int bcnt = 0, s_bcnt = 0;
   logic pb = 1'b0, s_pb = 1'b0;
   logic [63:0] mon_e, s_mon_e;
   int mon_n, s_mon_n;

   always @(negedge clk) begin
      if (reset) begin
         bcnt = 0; pb = 1'b0;
      end else begin
         if (busy) bcnt++;
         else if (pb) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL wb_unexpected actual=%h expected=none", {HI, LO});
            end else begin
               mon_e = exp_q.pop_front();
               mon_n = lat_q.pop_front();
               check("wb_hilo", {HI, LO}, mon_e);
               check("busy_len", bcnt, mon_n);
            end
            bcnt = 0;
         end
         pb = busy;
      end
   end

   always @(negedge clk) begin
      if (reset) begin
         s_bcnt = 0; s_pb = 1'b0;
      end else begin
         if (s_busy) s_bcnt++;
         else if (s_pb) begin
            if (s_exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL s_wb_unexpected actual=%h%h expected=none", s_hi, s_lo);
            end else begin
               s_mon_e = s_exp_q.pop_front();
               s_mon_n = s_lat_q.pop_front();
               check("s_wb_hilo", {16'b0, s_hi, 16'b0, s_lo}, s_mon_e);
               check("s_busy_len", s_bcnt, s_mon_n);
            end
            s_bcnt = 0;
         end
         s_pb = s_busy;
      end
   end

   // Drivers are entered on a negedge; inputs change there, away from posedge.
   task automatic issue(logic [3:0] op, logic [31:0] a, logic [31:0] b, bit push);
      MDUctrl = op; dataA = a; dataB = b; start = 1'b1;
      if (push) begin
         exp_q.push_back(ref_md(32, op, a, b));
         lat_q.push_back((op <= 4'd2) ? 5 : 10);
      end
      @(negedge clk);
      start = 1'b0; MDUctrl = 4'd0; dataA = $urandom; dataB = $urandom;
   endtask

   task automatic wait_idle(bit noise);
      int k = 0;
      while (busy && k < 60) begin
         if (noise) begin
            start = 1'($urandom_range(0, 1)); MDUctrl = 4'($urandom_range(0, 15));
            dataA = $urandom; dataB = $urandom;
         end
         @(negedge clk);
         k++;
      end
      start = 1'b0; MDUctrl = 4'd0;
      if (busy) begin
         checks++; errors++;
         $display("FAIL wait_idle actual=busy expected=idle");
      end
   endtask

   task automatic do_md(logic [3:0] op, logic [31:0] a, logic [31:0] b, bit noise);
      issue(op, a, b, 1'b1);
      wait_idle(noise);
      {m_hi, m_lo} = ref_md(32, op, a, b);
   endtask

   task automatic do_mt(logic [3:0] op, logic [31:0] a);
      issue(op, a, $urandom, 1'b0);
      if (op == 4'd7) m_hi = a; else m_lo = a;
      check("mt_hilo", {HI, LO}, {m_hi, m_lo});
      check("mt_busy", busy, 0);
   endtask

   task automatic check_reads();
      MDUctrl = 4'd5; #1 check("mfhi", result, m_hi);
      MDUctrl = 4'd6; #1 check("mflo", result, m_lo);
      MDUctrl = 4'd0; #1 check("rd_none", result, 0);
   endtask

   task automatic s_md(logic [3:0] op, logic [15:0] a, logic [15:0] b);
      int k = 0;
      s_ctrl = op; s_dataA = a; s_dataB = b; s_start = 1'b1;
      s_exp_q.push_back(ref_md(16, op, {16'b0, a}, {16'b0, b}));
      s_lat_q.push_back((op <= 4'd2) ? 1 : 3);
      @(negedge clk);
      s_start = 1'b0; s_ctrl = 4'd0; s_dataA = 16'($urandom); s_dataB = 16'($urandom);
      while (s_busy && k < 20) begin @(negedge clk); k++; end
      if (s_busy) begin
         checks++; errors++;
         $display("FAIL s_wait_idle actual=busy expected=idle");
      end
   endtask

   function automatic logic [31:0] pick_a();
      case ($urandom_range(0, 5))
         0: return 32'h8000_0000;
         1: return 32'($urandom_range(0, 100));
         default: return $urandom;
      endcase
   endfunction

   function automatic logic [31:0] pick_b();
      case ($urandom_range(0, 6))
         0: return 32'h0;
         1: return 32'hFFFF_FFFF;
         2: return 32'($urandom_range(1, 9));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int quiet_bad;
      reset = 1'b1; start = 1'b0; MDUctrl = 4'd0; dataA = '0; dataB = '0;
      s_start = 1'b0; s_ctrl = 4'd0; s_dataA = '0; s_dataB = '0;
      m_hi = '0; m_lo = '0;
      #2;
      check("rst_busy", {busy, s_busy}, 0);
      check("rst_hilo", {HI, LO}, 0);
      check("s_rst_hilo", {s_hi, s_lo}, 0);
      @(negedge clk); @(negedge clk);
      reset = 1'b0;

      do_md(4'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
      do_md(4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
      check_reads();
      do_md(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
      do_md(4'd4, 32'd7, 32'd2, 1'b0);
      do_md(4'd4, 32'd5, 32'd0, 1'b0);
      do_md(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      check_reads();

      // Start while busy: MTHI and DIV must be ignored, MFLO sees the old LO.
      issue(4'd1, 32'd3, 32'd4, 1'b1);
      MDUctrl = 4'd7; dataA = 32'hAAAA; start = 1'b1;
      @(negedge clk);
      MDUctrl = 4'd3; dataA = 32'd1; dataB = 32'd1;
      @(negedge clk);
      start = 1'b0; MDUctrl = 4'd6;
      #1 check("mflo_busy", result, m_lo);
      MDUctrl = 4'd0;
      wait_idle(1'b0);
      m_hi = 32'd0; m_lo = 32'd12;
      do_mt(4'd8, 32'h55);
      check_reads();

      // Reset during cycle 4 of a DIV: no writeback may follow.
      issue(4'd3, 32'd100, 32'd7, 1'b0);
      repeat (3) @(negedge clk);
      #2 reset = 1'b1;
      #1 check("rst_mid_busy", busy, 0);
      check("rst_mid_hilo", {HI, LO}, 0);
      @(negedge clk);
      #2 reset = 1'b0;
      m_hi = '0; m_lo = '0;
      quiet_bad = 0;
      repeat (12) begin
         @(negedge clk);
         if (busy || HI != 0 || LO != 0) quiet_bad++;
      end
      check("post_rst_quiet", quiet_bad, 0);

      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 3) == 0) do_mt(4'($urandom_range(7, 8)), $urandom);
         else do_md(4'($urandom_range(1, 4)), pick_a(), pick_b(), 1'(i % 2));
         if (i % 8 == 0) check_reads();
      end

      s_md(4'd1, 16'h8000, 16'h0002);
      for (int i = 0; i < 20; i++) begin
         s_md(4'($urandom_range(1, 4)),
              ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom),
              ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom_range(0, 20)));
      end

      repeat (3) @(negedge clk);
      check("queue_empty", exp_q.size() + s_exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/e_mdu.md
# e_mdu

Parametrised multiply/divide unit for the E stage of the pipelined MIPS core, sitting beside the ALU. It executes MULT/MULTU/DIV/DIVU over a configurable number of cycles, and owns the HI/LO registers. It serves MFHI/MFLO combinationally and accepts MTHI/MTLO writes. The unit exposes `busy` so the hazard unit can stall MD-class instructions issued while an operation is in flight.

## Interface
- `WIDTH`, 32: operand, HI and LO width.
- `MULT_CYCLES`, 5: multiply latency in cycles; must be ≥1.
- `DIV_CYCLES`, 10: divide latency in cycles; must be ≥1.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `dataA`  in  WIDTH  rs operand (dividend / multiplicand / MT source).
- `dataB`  in  WIDTH  rt operand (divisor / multiplier).
- `MDUctrl`  in  4  operation select:
  - 0000 none, 0001 MULT, 0010 MULTU, 0011 DIV, 0100 DIVU
  - 0101 MFHI, 0110 MFLO, 0111 MTHI, 1000 MTLO
  - other codes act as none.
- `start`  in  1  strobe qualifying MULT/MULTU/DIV/DIVU/MTHI/MTLO for this cycle.
- `busy`  out  1  registered; high while a mult/div is in flight.
- `HI`  out  WIDTH  current HI register.
- `LO`  out  WIDTH  current LO register.
- `result`  out  WIDTH  combinational read data: HI for MFHI, LO for MFLO, 0 otherwise.

## Operation
- State machine: IDLE and BUSY, with a down-counter sized to max(MULT_CYCLES, DIV_CYCLES).
- **Accepting an operation (IDLE).** When `start`=1 and `MDUctrl` is MULT/MULTU/DIV/DIVU:
  - latch the opcode;
  - compute the result from `dataA`/`dataB` and hold it in pending registers;
  - load the counter with the op's latency;
  - go to BUSY.
- **BUSY.** Decrement each cycle. On the edge where the counter expires, write HI/LO from the pending registers, clear `busy` and return to IDLE.
- **`start` while BUSY.** Ignored entirely for all ops, including MTHI/MTLO. Pending and HI/LO are unaffected.
- **MTHI/MTLO in IDLE with `start`=1.** HI (or LO) ← `dataA` at the edge. There is no busy period.
- **MFHI/MFLO.** Do not need `start`. They read the current register value, so in BUSY they return the pre-operation value; the hazard unit is responsible for stalling.
- **Multiply.**
  - Full 2·WIDTH-bit product; HI = upper WIDTH bits, LO = lower WIDTH bits.
  - MULT treats operands as two's complement; MULTU treats them as unsigned.
- **Divide.**
  - LO = quotient, truncated toward zero; HI = remainder, carrying the sign of the dividend.
  - DIV is signed; DIVU is unsigned.
- **Divide by zero.** HI = `dataA`, LO = all ones. Takes the full DIV_CYCLES.
- **Signed overflow (DIV of most-negative value by −1).** LO = most-negative value, HI = 0.

## Timing
- **Reset.** `busy`=0, HI=0, LO=0, state IDLE, counter=0, pending cleared. The effect is immediate (asynchronous) and overrides everything.
- **Reset mid-operation.** The in-flight op is discarded; there is no later writeback.
- **Mult/div latency.** With `start` sampled at edge T:
  - `busy`=1 after T through edge T+N, where N = MULT_CYCLES or DIV_CYCLES;
  - HI/LO take the new value after edge T+N, the same edge on which `busy` falls;
  - `busy` is high for exactly N cycles.
- **Back-to-back.** A new `start` is accepted in the first cycle `busy` reads 0, i.e. directly after the writeback edge.
- **MT ops.** Effective after the sampling edge; `busy` is never asserted.
- **Operand capture.** Operands are captured only at the accept edge. Later changes to `dataA`/`dataB` have no effect on the in-flight op.

## Test plan
- **MULT sign handling.** MULT 0xFFFFFFFF × 0x00000002, then MULTU with the same operands:
  - MULT → `busy` high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE;
  - MULTU → HI=0x00000001, LO=0xFFFFFFFE.
- **DIV sign handling.** DIV 0xFFFFFFF9 (−7) ÷ 2, then DIVU 7 ÷ 2:
  - DIV → `busy` 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF;
  - DIVU → LO=3, HI=1.
- **Divide corner cases.**
  - DIVU 5 ÷ 0 → HI=5, LO=0xFFFFFFFF after 10 cycles.
  - DIV 0x80000000 ÷ 0xFFFFFFFF → LO=0x80000000, HI=0.
- **Start while busy.** MULT 3×4; during BUSY issue MTHI 0xAAAA and DIV 1÷1 with `start`=1:
  - both are ignored; final HI=0, LO=12;
  - MFLO during BUSY returns the old LO;
  - MTLO 0x55 on the cycle after `busy` falls → LO=0x55.
- **Reset mid-operation.** Assert `reset` during cycle 4 of a DIV 100÷7:
  - `busy`, HI and LO go to 0 immediately;
  - after release, nothing is written in the following 10 cycles.
- **Parametrised latency.** Build with WIDTH=16, MULT_CYCLES=1, DIV_CYCLES=3 and run MULT 0x8000 × 0x0002:
  - `busy` high 1 cycle;
  - HI=0xFFFF, LO=0x0000.
